// File: rtl/example_01_if.sv
// rtl/example_01_if.sv - operand, clear and decision-history bundle for example_01
interface example_01_if #(
    parameter int CNT_W = 8
);
    logic             A;
    logic             B;
    logic             C;
    logic             D;
    logic             E;
    logic             F;
    logic             clr;
    logic             Y;
    logic             y_q;
    logic             y_rise;
    logic             y_fall;
    logic [CNT_W-1:0] hit_cnt;
    logic             hit_sat;

    modport master (
        output A, B, C, D, E, F, clr,
        input  Y, y_q, y_rise, y_fall, hit_cnt, hit_sat
    );

    modport slave (
        input  A, B, C, D, E, F, clr,
        output Y, y_q, y_rise, y_fall, hit_cnt, hit_sat
    );
endinterface

// File: rtl/example_01.sv
// rtl/example_01.sv - sum-of-products qualifier with registered edge pulses and saturating hit count
module example_01 #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    example_01_if.slave  bus
);
    logic             y;
    logic             y_q_r;
    logic             y_rise_r;
    logic             y_fall_r;
    logic [CNT_W-1:0] cnt_r;

    assign y = (bus.A & bus.B) | (~bus.C & bus.D) | (bus.E & ~bus.F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_r    <= 1'b0;
            y_rise_r <= 1'b0;
            y_fall_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            y_q_r <= y;
            // clr suppresses pulses and count but the y_q history still advances
            if (bus.clr) begin
                y_rise_r <= 1'b0;
                y_fall_r <= 1'b0;
                cnt_r    <= '0;
            end else begin
                y_rise_r <= y & ~y_q_r;
                y_fall_r <= ~y & y_q_r;
                if (y && (cnt_r != {CNT_W{1'b1}})) begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end

    assign bus.Y       = y;
    assign bus.y_q     = y_q_r;
    assign bus.y_rise  = y_rise_r;
    assign bus.y_fall  = y_fall_r;
    assign bus.hit_cnt = cnt_r;
    assign bus.hit_sat = (cnt_r == {CNT_W{1'b1}});
endmodule

// File: tb/tb_example_01.sv
// tb/tb_example_01.sv - directed and random checks of example_01
module tb_example_01;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    example_01_if #(.CNT_W(CNT_W)) bus ();

    example_01 #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Independent reference of the decision equation; v = {A,B,C,D,E,F}
    function automatic logic ref_y(input logic [5:0] v);
        return (v[5] & v[4]) | (~v[3] & v[2]) | (v[1] & ~v[0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] v);
        {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic q, input logic r, input logic f,
                              input int cnt);
        check({tag, "_y_q"},    32'(bus.y_q),     32'(q));
        check({tag, "_y_rise"}, 32'(bus.y_rise),  32'(r));
        check({tag, "_y_fall"}, 32'(bus.y_fall),  32'(f));
        check({tag, "_hit_cnt"}, 32'(bus.hit_cnt), 32'(cnt));
    endtask

    initial begin
        logic [5:0] v;
        logic       prev_y;
        logic       prev_q;
        int         exp_cnt;

        bus.clr = 1'b0;
        set_in(6'b000000);
        #1;
        check_regs("reset", 1'b0, 1'b0, 1'b0, 0);
        check("reset_hit_sat", 32'(bus.hit_sat), 32'd0);

        // Combinational vectors while still in reset
        set_in(6'b000000); #5; check("comb_000000", 32'(bus.Y), 32'd0);
        set_in(6'b101110); #5; check("comb_101110", 32'(bus.Y), 32'd1);
        set_in(6'b110101); #5; check("comb_110101", 32'(bus.Y), 32'd1);
        set_in(6'b011011); #5; check("comb_011011", 32'(bus.Y), 32'd0);
        set_in(6'b111100); #5; check("comb_111100", 32'(bus.Y), 32'd1);

        @(negedge clk);
        rst = 1'b0;

        // Build up state, then assert reset between edges
        set_in(6'b110000);
        step();
        check_regs("first_edge", 1'b1, 1'b1, 1'b0, 1);
        step();
        step();
        check_regs("pre_rst", 1'b1, 1'b0, 1'b0, 3);
        #2;
        rst = 1'b1;
        #1;
        check_regs("async_rst", 1'b0, 1'b0, 1'b0, 0);
        check("async_rst_Y", 32'(bus.Y), 32'd1);
        set_in(6'b000100);
        #1;
        check("rst_Y_track", 32'(bus.Y), 32'd1);
        set_in(6'b001100);
        #1;
        check("rst_Y_track0", 32'(bus.Y), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Edge pulses: Y = 0,1,1,0
        set_in(6'b000000); step(); check_regs("pulse1", 1'b0, 1'b0, 1'b0, 0);
        set_in(6'b000010); step(); check_regs("pulse2", 1'b1, 1'b1, 1'b0, 1);
        set_in(6'b000010); step(); check_regs("pulse3", 1'b1, 1'b0, 1'b0, 2);
        set_in(6'b000000); step(); check_regs("pulse4", 1'b0, 1'b0, 1'b1, 2);

        bus.clr = 1'b1;
        step();
        check_regs("clr_idle", 1'b0, 1'b0, 1'b0, 0);
        bus.clr = 1'b0;

        // Counting
        set_in(6'b110000);
        for (int i = 0; i < 10; i++) step();
        check_regs("count10", 1'b1, 1'b0, 1'b0, 10);
        set_in(6'b000000);
        for (int i = 0; i < 3; i++) step();
        check_regs("hold10", 1'b0, 1'b0, 1'b0, 10);
        set_in(6'b110000);
        bus.clr = 1'b1;
        step();
        check_regs("clr_wins", 1'b1, 1'b0, 1'b0, 0);
        bus.clr = 1'b0;

        // Saturation
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (exp_cnt < 255) exp_cnt++;
            check("sat_hit_cnt", 32'(bus.hit_cnt), 32'(exp_cnt));
            check("sat_hit_sat", 32'(bus.hit_sat), (exp_cnt == 255) ? 32'd1 : 32'd0);
        end

        // Random compare against the reference equation
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        prev_q = bus.y_q;
        for (int i = 0; i < 1000; i++) begin
            v = 6'($urandom_range(63));
            set_in(v);
            #1;
            check("rand_Y", 32'(bus.Y), 32'(ref_y(v)));
            prev_y = ref_y(v);
            step();
            check("rand_y_q",    32'(bus.y_q),    32'(prev_y));
            check("rand_y_rise", 32'(bus.y_rise), 32'(prev_y & ~prev_q));
            check("rand_y_fall", 32'(bus.y_fall), 32'(~prev_y & prev_q));
            prev_q = prev_y;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/example_01.md
# example_01

Six-input combinational decision function with a registered post-processing stage. Inputs A–F produce the decision output Y combinationally. The decision is also captured on the clock to provide a stable copy of Y, single-cycle rise/fall pulses, and a saturating count of asserted cycles. The block is a leaf cell used wherever a fixed sum-of-products qualifier is needed alongside its registered history.

## Interface
- CNT_W, default 8: width of the asserted-cycle counter.
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  asynchronous, active-high reset.
- A, B, C, D, E, F  input  1 each  decision operands.
- clr  input  1  synchronous clear of the counter and pulse outputs.
- Y  output  1  combinational decision, Y = (A & B) | (~C & D) | (E & ~F).
- y_q  output  1  Y registered on the rising edge of clk.
- y_rise  output  1  one-cycle pulse when y_q goes 0→1.
- y_fall  output  1  one-cycle pulse when y_q goes 1→0.
- hit_cnt  output  CNT_W  number of clock edges sampled with Y=1, saturating.
- hit_sat  output  1  high when hit_cnt equals 2^CNT_W−1.

Clocking and reset are fixed: one clock; reset is asynchronous and active-high.

## Operation
- Y is purely combinational from A–F. It has no dependence on clk, rst or clr. It remains valid during reset.
- Truth rule: Y=1 when any of these terms is true: (A and B), (D and not C), (E and not F). Otherwise Y=0.
- On each rising clk edge with rst low:
  - y_q ← Y.
  - y_rise ← Y & ~y_q.
  - y_fall ← ~Y & y_q.
  - If clr=1: hit_cnt ← 0, y_rise ← 0, y_fall ← 0. y_q still loads Y.
  - Else if Y=1 and hit_cnt < max: hit_cnt ← hit_cnt + 1.
  - Else hit_cnt holds. At max it does not wrap.
- hit_sat is combinational: hit_sat = (hit_cnt == all ones).
- Unknown (X/Z) operands give an unspecified Y. Registered outputs need only be correct once inputs are known.

## Timing
- Y latency: zero cycles. It settles within the same simulation step as an input change.
- y_q, y_rise, y_fall, hit_cnt: one-cycle latency from Y.
- Reset values, applied immediately on rst assertion regardless of clk: y_q=0, y_rise=0, y_fall=0, hit_cnt=0. Hence hit_sat=0.
- Reset mid-count discards the count. After rst deasserts, the first rising edge operates normally.
- Because y_q resets to 0, Y=1 at the first edge after reset produces y_rise=1.
- clr and Y=1 on the same edge: clr wins and hit_cnt=0.
- Saturation: at hit_cnt=255 (CNT_W=8) with Y=1, hit_cnt stays 255 and hit_sat stays 1.

## Test plan
- Combinational vectors, no clock required. Apply each vector for 5 time units and check Y:
  - A..F=000000 → Y=0.
  - 101110 → Y=1.
  - 110101 → Y=1.
  - 011011 → Y=0.
  - 111100 → Y=1.
- Reset:
  - Drive Y=1 with clk running, then pulse rst asynchronously between edges. y_q, y_rise, y_fall and hit_cnt must go to 0 immediately.
  - Y must keep tracking A–F throughout.
- Edge pulses, sequence Y=0,1,1,0 over 4 edges:
  - y_q=0,1,1,0.
  - y_rise high only on the 2nd edge.
  - y_fall high only on the 4th edge.
- Counting:
  - Hold Y=1 for 10 edges → hit_cnt=10.
  - Drop Y to 0 for 3 edges → hit_cnt=10.
  - Assert clr together with Y=1 → hit_cnt=0.
- Saturation (CNT_W=8):
  - Hold Y=1 for 300 edges → hit_cnt=255 and hit_sat=1.
  - Never wraps to 0.
- Random compare: 1000 random A–F vectors. Check Y against the equation and y_q against the previous cycle's Y.
